// File: rtl/tff_counter.sv
// Modulo up/down counter built from per-bit toggle flops, with load, enable and a wrap pulse.
// Latency: count updates one edge after en/load are sampled; tc is combinational; done is registered.
// No backpressure: the counter accepts en/load on every edge; clr overrides everything asynchronously.
//
// Ports:
//   clk      - rising-edge clock
//   clr      - asynchronous active-high reset (count = 0, done = 0)
//   en       - count enable
//   up       - direction, 1 = increment, 0 = decrement
//   load     - synchronous load strobe (beats en)
//   load_val - value to load, saturated to TERMINAL
//   count    - registered count, range 0..TERMINAL
//   tc       - high when the coming edge wraps the count
//   done     - one-cycle pulse in the cycle after a wrap edge
module tff_counter #(
    parameter int          WIDTH    = 6,
    parameter int unsigned TERMINAL = 31
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] TERM = TERMINAL[WIDTH-1:0];

    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] load_sat;
    logic             at_top;
    logic             at_bottom;

    assign at_top    = (count == TERM);
    assign at_bottom = (count == '0);

    // Out-of-range load values clamp to the top of the count range.
    assign load_sat = (load_val > TERM) ? TERM : load_val;

    // A wrap is exactly an enabled, non-load edge sitting on the boundary
    // for the current direction, so tc doubles as the wrap event for done.
    assign tc = en & ~load & ((up & at_top) | (~up & at_bottom));

    always_comb begin
        next_count = count;
        if (load) begin
            next_count = load_sat;
        end else if (en) begin
            if (up) begin
                next_count = at_top ? '0 : count + WIDTH'(1);
            end else begin
                next_count = at_bottom ? TERM : count - WIDTH'(1);
            end
        end
    end

    // Each bit is a toggle cell: it flips only where the chosen next value
    // differs from the current one.
    assign toggle = count ^ next_count;

    for (genvar i = 0; i < WIDTH; i++) begin : g_tff
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                count[i] <= 1'b0;
            end else if (toggle[i]) begin
                count[i] <= ~count[i];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            done <= 1'b0;
        end else begin
            done <= tc;
        end
    end

endmodule

// File: tb/tb_tff_counter.sv
// Bench for tff_counter with WIDTH = 4, TERMINAL = 9.
// Each stimulus cycle pushes the hand-computed values the outputs must show in that
// cycle; a monitor on the falling edge pops and compares them.
module tb_tff_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             clr;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;

    typedef struct {
        int       idx;
        logic [3:0] cnt;
        logic     tc;
        logic     done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_idx  = 0;

    tff_counter #(.WIDTH(WIDTH), .TERMINAL(9)) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: just after a rising edge, apply inputs and record
    // what count/tc/done must read before the next rising edge.
    task automatic vec(input logic c, input logic e, input logic u, input logic l,
                       input logic [3:0] lv, input logic [3:0] ec, input logic et,
                       input logic ed);
        exp_t x;
        @(posedge clk);
        #1;
        clr      = c;
        en       = e;
        up       = u;
        load     = l;
        load_val = lv;
        x.idx  = vec_idx;
        x.cnt  = ec;
        x.tc   = et;
        x.done = ed;
        exp_q.push_back(x);
        vec_idx++;
    endtask

    task automatic cmp(input string name, input int idx, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            cmp("count", x.idx, int'(count), int'(x.cnt));
            cmp("tc",    x.idx, int'(tc),    int'(x.tc));
            cmp("done",  x.idx, int'(done),  int'(x.done));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;

        //   clr en up ld lv   count tc done
        // Reset state
        vec(1, 0, 0, 0, 0,    0, 0, 0);
        // Up-count 1..9 then wrap to 0
        vec(0, 1, 1, 0, 0,    0, 0, 0);
        vec(0, 1, 1, 0, 0,    1, 0, 0);
        vec(0, 1, 1, 0, 0,    2, 0, 0);
        vec(0, 1, 1, 0, 0,    3, 0, 0);
        vec(0, 1, 1, 0, 0,    4, 0, 0);
        vec(0, 1, 1, 0, 0,    5, 0, 0);
        vec(0, 1, 1, 0, 0,    6, 0, 0);
        vec(0, 1, 1, 0, 0,    7, 0, 0);
        vec(0, 1, 1, 0, 0,    8, 0, 0);
        vec(0, 1, 1, 0, 0,    9, 1, 0);
        vec(0, 1, 1, 0, 0,    0, 0, 1);
        // Clear (count would have been 1), then down-count from reset
        vec(1, 0, 0, 0, 0,    0, 0, 0);
        vec(0, 1, 0, 0, 0,    0, 1, 0);
        vec(0, 1, 0, 0, 0,    9, 0, 1);
        vec(0, 1, 0, 0, 0,    8, 0, 0);
        // Load beats enable; out-of-range load saturates
        vec(0, 1, 1, 1, 5,    7, 0, 0);
        vec(0, 1, 1, 1, 12,   5, 0, 0);
        // Reversal at 9 going down is not a wrap
        vec(0, 1, 0, 0, 0,    9, 0, 0);
        vec(0, 1, 1, 0, 0,    8, 0, 0);
        // At terminal but disabled: no tc
        vec(0, 0, 1, 0, 0,    9, 0, 0);
        vec(0, 0, 0, 1, 0,    9, 0, 0);
        // Reversal at 0 going up is not a wrap
        vec(0, 1, 1, 0, 0,    0, 0, 0);
        vec(0, 0, 1, 0, 0,    1, 0, 0);
        // Hold at 3 for three edges
        vec(0, 0, 0, 1, 3,    1, 0, 0);
        vec(0, 0, 0, 0, 0,    3, 0, 0);
        vec(0, 0, 0, 0, 0,    3, 0, 0);
        vec(0, 0, 0, 0, 0,    3, 0, 0);
        vec(0, 1, 1, 0, 0,    3, 0, 0);
        vec(0, 1, 1, 0, 0,    4, 0, 0);
        vec(0, 1, 1, 0, 0,    5, 0, 0);
        vec(0, 0, 1, 0, 0,    6, 0, 0);
        // Async clear mid-run at 6, held, then resume
        vec(1, 1, 1, 0, 0,    0, 0, 0);
        vec(1, 1, 1, 0, 0,    0, 0, 0);
        vec(0, 1, 1, 0, 0,    0, 0, 0);
        vec(0, 1, 1, 0, 0,    1, 0, 0);
        // Wrap, then clear drops the pending done pulse
        vec(0, 1, 1, 1, 9,    2, 0, 0);
        vec(0, 1, 1, 0, 0,    9, 1, 0);
        vec(1, 0, 0, 0, 0,    0, 0, 0);
        vec(0, 0, 0, 0, 0,    0, 0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tff_counter.md
# tff_counter

Parametrised modulo up/down counter built from per-bit toggle-flop cells: the next-generation form of the single `tff` cell. It lets multdiv and the control path count iterations, e.g. 32 multiply/divide steps, without hand-wiring toggle chains. It adds width and terminal-count parameters, direction control, synchronous load, clock enable and a registered wrap pulse (`done`). A single `tff` has none of these.

## Interface
- `WIDTH`, default 6: counter width in bits; legal range 1..32.
- `TERMINAL`, default 31: highest count value; count range is 0..TERMINAL; must satisfy `TERMINAL <= 2**WIDTH-1`.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `clr`  input  1: asynchronous, active-high reset.
- `en`  input  1: count enable.
- `up`  input  1: direction; 1 = increment, 0 = decrement.
- `load`  input  1: synchronous load strobe.
- `load_val`  input  WIDTH: value to load.
- `count`  output  WIDTH: current count, registered.
- `tc`  output  1: terminal-count flag, combinational.
- `done`  output  1: registered one-cycle wrap pulse.

## Operation
- **State:** `count` bits (WIDTH toggle flops) plus the `done` flop; no other state.
- **Reset:** `clr` high forces `count = 0` and `done = 0` immediately, without waiting for a clock edge. Both hold while `clr` is high, and `clr` overrides every other input.
- **Per-edge priority, highest first:** `clr`, then `load`, then `en`, then hold.
- **Load:** `count <= min(load_val, TERMINAL)`. An out-of-range `load_val` saturates to TERMINAL. `done <= 0`. `en` and `up` are ignored that cycle.
- **Enabled, `up = 1`:** `count <= (count == TERMINAL) ? 0 : count + 1`.
- **Enabled, `up = 0`:** `count <= (count == 0) ? TERMINAL : count - 1`.
- **Hold:** `en = 0` and `load = 0` leaves `count` unchanged; `done <= 0`.
- **Wrap event:** an edge where `en = 1`, `load = 0` and `tc = 1`. On that edge `done <= 1`; on every other edge `done <= 0`.
- **`tc`:** `tc = en & ~load & ((up & count == TERMINAL) | (~up & count == 0))`. It tells the consumer that the coming edge wraps.
- **Toggle structure:** each bit's toggle input is `T_i = count_i ^ next_i`. `next` is the value selected above, so a toggle cell with `T = 0` holds its value.
- **`TERMINAL = 2**WIDTH-1`:** the wrap equals natural binary overflow and underflow; no special compare is needed, but the behaviour is identical.
- **`TERMINAL = 0`:** `count` stays 0. Every enabled edge is a wrap, so `done` stays high while `en = 1`.
- **Direction change:** may occur on any cycle and takes effect on the next edge with no penalty. A reversal at a boundary is not a wrap unless `tc` is high for the new direction.

## Timing
- `count` changes only on a rising `clk` edge, or asynchronously on `clr`.
- Counter latency: `en` sampled at edge N gives the new `count` after edge N.
- `tc` is combinational and valid in the same cycle as its inputs.
- `done` is high for exactly the cycle after the wrap edge, coincident with `count` showing 0 (up) or TERMINAL (down).
- Back-to-back wraps (`TERMINAL = 0` case) keep `done` continuously high.
- `clr` released asynchronously: the first counting edge is the first rising edge after deassertion. The consumer must meet recovery time; no synchroniser is inside.
- `clr` asserted mid-count: `count` and `done` go to 0 within the same cycle, with no edge required. Any pending `done` is lost.

## Test plan
All scenarios use `WIDTH = 4`, `TERMINAL = 9`.
- **Reset then up-count:** `clr` pulse, then `en = 1`, `up = 1` for 10 edges. Response: `count` reads 1,2,…,9,0; `tc` is high only while `count = 9`; `done` is high only in the cycle `count` returns to 0.
- **Down-count from reset:** `clr`, then `en = 1`, `up = 0`. Response: `tc` is high at `count = 0` before the first edge; after that edge `count = 9` and `done = 1`; next edge `count = 8` and `done = 0`.
- **Load priority and saturation:**
  - `load = 1`, `load_val = 5`, `en = 1`, `up = 1`: `count = 5`, not 6; `done = 0`; `tc = 0` during the load cycle.
  - `load_val = 12`: `count = 9`.
- **Hold:** at `count = 3`, `en = 0` for 3 edges: `count` stays 3; `tc = 0`; `done = 0`.
- **Async reset mid-run:** `count = 6`, assert `clr` between edges. Response: `count = 0` and `done = 0` before the next edge; they stay 0 while `clr` is high and resume counting on the first edge after release.
- **Reversal at boundary:** `count = 9`, `up = 0`, `en = 1`: next `count = 8`; `done` stays 0. Repeat at `count = 0` with `up = 1`: next `count = 1`; `done = 0`.
